// File: rtl/neuron_seq_pkg.sv
// -----------------------------------------------------------------------------
// neuron_seq_pkg
//
// Shared types and width helpers for the time-multiplexed LUT neuron
// sequencer (neuron_lut_sequencer) and its table store (neuron_seq_tables).
//
// Contents:
//   seq_state_e       sequencer state: IDLE -> RUN -> HOLD -> IDLE
//   CFG_TT / CFG_CONN cfg_sel encodings (truth table / connectivity table)
//   idx_width()       bits needed to index one input activation bit
//   conn_width()      width of one connectivity word (FANIN packed indices)
// -----------------------------------------------------------------------------
package neuron_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    localparam logic CFG_TT   = 1'b0;
    localparam logic CFG_CONN = 1'b1;

    // A single-bit input vector still needs a 1-bit index field.
    function automatic int idx_width(input int in_bits);
        return (in_bits > 1) ? $clog2(in_bits) : 1;
    endfunction

    function automatic int conn_width(input int fanin, input int in_bits);
        return fanin * idx_width(in_bits);
    endfunction

endpackage

// File: rtl/neuron_seq_tables.sv
// -----------------------------------------------------------------------------
// neuron_seq_tables
//
// The two configuration stores shared by all neurons of the layer. Each is a
// simple dual-port distributed RAM: one write port driven by the config path
// and one registered (synchronous) read port driven by the pipeline.
//
// Ports:
//   clk           clock
//   tt_we_i       truth-table write enable
//   tt_waddr_i    truth-table write address {neuron, pattern}
//   tt_wdata_i    truth-table write data (OUT_BITS)
//   tt_raddr_i    truth-table read address {neuron, pattern}
//   tt_rdata_o    truth-table read data, valid the cycle after tt_raddr_i
//   conn_we_i     connectivity write enable
//   conn_waddr_i  connectivity write address (neuron)
//   conn_wdata_i  connectivity word, FANIN packed input indices
//   conn_raddr_i  connectivity read address (neuron)
//   conn_rdata_o  connectivity read data, valid the cycle after conn_raddr_i
// -----------------------------------------------------------------------------
module neuron_seq_tables #(
    parameter int NEURONS  = 16,
    parameter int FANIN    = 6,
    parameter int OUT_BITS = 2,
    parameter int CONN_W   = 36
) (
    input  logic                              clk,
    input  logic                              tt_we_i,
    input  logic [$clog2(NEURONS)+FANIN-1:0]  tt_waddr_i,
    input  logic [OUT_BITS-1:0]               tt_wdata_i,
    input  logic [$clog2(NEURONS)+FANIN-1:0]  tt_raddr_i,
    output logic [OUT_BITS-1:0]               tt_rdata_o,
    input  logic                              conn_we_i,
    input  logic [$clog2(NEURONS)-1:0]        conn_waddr_i,
    input  logic [CONN_W-1:0]                 conn_wdata_i,
    input  logic [$clog2(NEURONS)-1:0]        conn_raddr_i,
    output logic [CONN_W-1:0]                 conn_rdata_o
);

    localparam int TT_DEPTH = NEURONS << FANIN;

    logic [OUT_BITS-1:0] tt_mem   [TT_DEPTH];
    logic [CONN_W-1:0]   conn_mem [NEURONS];
    logic [OUT_BITS-1:0] tt_rdata_q;
    logic [CONN_W-1:0]   conn_rdata_q;

    // NOTE: the arrays and their read registers have no reset. Table contents
    // must survive a sequencer reset, and a reset on a RAM array prevents it
    // from mapping onto distributed memory.
    always_ff @(posedge clk) begin
        if (tt_we_i) begin
            tt_mem[tt_waddr_i] <= tt_wdata_i;
        end
        tt_rdata_q <= tt_mem[tt_raddr_i];
    end

    always_ff @(posedge clk) begin
        if (conn_we_i) begin
            conn_mem[conn_waddr_i] <= conn_wdata_i;
        end
        conn_rdata_q <= conn_mem[conn_raddr_i];
    end

    assign tt_rdata_o   = tt_rdata_q;
    assign conn_rdata_o = conn_rdata_q;

endmodule

// File: rtl/neuron_lut_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_lut_sequencer
//
// Evaluates NEURONS LogicNets-style LUT neurons of one layer by stepping a
// single shared truth-table store through them one per cycle. An accepted
// input vector is latched, then a 3-stage pipeline runs per neuron:
//   S0  read the neuron's connectivity word (FANIN input indices)
//   S1  gather the indexed input bits into a truth-table address and read
//       the truth table at {neuron, address}
//   S2  write the OUT_BITS result into the neuron's slice of out_data
// When the last slice has been written the block enters HOLD and presents
// out_data until the downstream handshake.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready input vector handshake (in_ready only in IDLE)
//   in_data           packed input activations
//   out_valid/out_ready output vector handshake (out_valid only in HOLD)
//   out_data          neuron n result at [n*OUT_BITS +: OUT_BITS]
//   cfg_we            table write strobe, honoured only while idle
//   cfg_sel           CFG_TT: truth table, CFG_CONN: connectivity table
//   cfg_addr          CFG_TT: {neuron, pattern}; CFG_CONN: neuron in low bits
//   cfg_data          CFG_TT: low OUT_BITS; CFG_CONN: index k at [k*W +: W]
//   cfg_err           one-cycle pulse after a write rejected while busy
//   busy              high outside IDLE
//
// Build option NEURON_SEQ_PERF_CNT_EN adds:
//   perf_samples      output handshakes, wrapping 32-bit count
//   perf_stall        HOLD cycles with out_ready low, saturating 32-bit count
// -----------------------------------------------------------------------------
module neuron_lut_sequencer
    import neuron_seq_pkg::*;
#(
    parameter int IN_BITS  = 64,
    parameter int FANIN    = 6,
    parameter int OUT_BITS = 2,
    parameter int NEURONS  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [IN_BITS-1:0]                    in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NEURONS*OUT_BITS-1:0]           out_data,
    input  logic                                  cfg_we,
    input  logic                                  cfg_sel,
    input  logic [$clog2(NEURONS)+FANIN-1:0]      cfg_addr,
    input  logic [conn_width(FANIN, IN_BITS)-1:0] cfg_data,
    output logic                                  cfg_err,
    output logic                                  busy
`ifdef NEURON_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                           perf_samples,
    output logic [31:0]                           perf_stall
`endif
);

    localparam int NW = $clog2(NEURONS);
    localparam int IW = idx_width(IN_BITS);
    localparam int CW = conn_width(FANIN, IN_BITS);
    localparam logic [NW-1:0] LAST_N = NW'(NEURONS - 1);

    seq_state_e                  state_q;
    logic [IN_BITS-1:0]          in_q;
    logic [NW-1:0]               cnt_q;
    logic                        issuing_q;
    logic                        s1_valid_q;
    logic [NW-1:0]               s1_n_q;
    logic                        s2_valid_q;
    logic [NW-1:0]               s2_n_q;
    logic                        last_done_q;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic                        busy_q;
    logic                        cfg_err_q;
    logic [NEURONS*OUT_BITS-1:0] out_data_q;

    logic [CW-1:0]               conn_rdata;
    logic [OUT_BITS-1:0]         tt_rdata;
    logic [FANIN-1:0]            gather_addr_d;
    logic                        cfg_take_d;
    logic                        tt_we_d;
    logic                        conn_we_d;

    // Writes are only taken while idle; an accept in the same cycle is fine
    // because the first table read happens on the following cycle.
    assign cfg_take_d = cfg_we & ~busy_q;
    assign tt_we_d    = cfg_take_d & (cfg_sel == CFG_TT);
    assign conn_we_d  = cfg_take_d & (cfg_sel == CFG_CONN);

    // S1 gather: address bit k is the input bit named by index k. Indices
    // beyond the vector fall back to bit 0.
    // NOTE: every output of a combinational block gets a default first, so a
    // path that skips an assignment cannot infer a latch.
    always_comb begin
        gather_addr_d = '0;
        for (int k = 0; k < FANIN; k++) begin
            if (int'(conn_rdata[k*IW +: IW]) < IN_BITS) begin
                gather_addr_d[k] = in_q[conn_rdata[k*IW +: IW]];
            end else begin
                gather_addr_d[k] = in_q[0];
            end
        end
    end

    neuron_seq_tables #(
        .NEURONS  (NEURONS),
        .FANIN    (FANIN),
        .OUT_BITS (OUT_BITS),
        .CONN_W   (CW)
    ) u_tables (
        .clk          (clk),
        .tt_we_i      (tt_we_d),
        .tt_waddr_i   (cfg_addr),
        .tt_wdata_i   (cfg_data[OUT_BITS-1:0]),
        .tt_raddr_i   ({s1_n_q, gather_addr_d}),
        .tt_rdata_o   (tt_rdata),
        .conn_we_i    (conn_we_d),
        .conn_waddr_i (cfg_addr[NW-1:0]),
        .conn_wdata_i (cfg_data),
        .conn_raddr_i (cnt_q),
        .conn_rdata_o (conn_rdata)
    );

    // FSM, issue counter and pipeline valids. S0 is the connectivity read
    // issued from cnt_q; s1_* tags the connectivity data, s2_* tags the
    // truth-table data. HOLD is entered the cycle after the last slice lands,
    // which places out_valid NEURONS+3 cycles after the accepting edge.
    // NOTE: all state below uses non-blocking assignments so each register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            issuing_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            last_done_q <= 1'b0;
        end else begin
            cfg_err_q   <= cfg_we & busy_q;

            s1_valid_q  <= issuing_q;
            s1_n_q      <= cnt_q;
            s2_valid_q  <= s1_valid_q;
            s2_n_q      <= s1_n_q;
            last_done_q <= s2_valid_q && (s2_n_q == LAST_N);

            if (s2_valid_q) begin
                out_data_q[s2_n_q*OUT_BITS +: OUT_BITS] <= tt_rdata;
            end

            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_q       <= in_data;
                        cnt_q      <= '0;
                        issuing_q  <= 1'b1;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (issuing_q) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_N) begin
                            issuing_q <= 1'b0;
                        end
                    end
                    if (last_done_q) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;

`ifdef NEURON_SEQ_PERF_CNT_EN
    logic [31:0] perf_samples_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_samples_q <= '0;
            perf_stall_q   <= '0;
        end else if (state_q == HOLD) begin
            if (out_ready) begin
                perf_samples_q <= perf_samples_q + 32'd1;
            end else if (perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_samples = perf_samples_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_neuron_lut_sequencer.sv
module tb_neuron_lut_sequencer;

    localparam int IN_BITS  = 64;
    localparam int FANIN    = 6;
    localparam int OUT_BITS = 2;
    localparam int NEURONS  = 16;
    localparam int AW       = 10;
    localparam int CW       = 36;
    localparam int LATENCY  = NEURONS + 3;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         in_valid = 1'b0;
    logic                         in_ready;
    logic [IN_BITS-1:0]           in_data = '0;
    logic                         out_valid;
    logic                         out_ready = 1'b0;
    logic [NEURONS*OUT_BITS-1:0]  out_data;
    logic                         cfg_we = 1'b0;
    logic                         cfg_sel = 1'b0;
    logic [AW-1:0]                cfg_addr = '0;
    logic [CW-1:0]                cfg_data = '0;
    logic                         cfg_err;
    logic                         busy;
`ifdef NEURON_SEQ_PERF_CNT_EN
    logic [31:0]                  perf_samples;
    logic [31:0]                  perf_stall;
`endif

    neuron_lut_sequencer #(
        .IN_BITS  (IN_BITS),
        .FANIN    (FANIN),
        .OUT_BITS (OUT_BITS),
        .NEURONS  (NEURONS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
`ifdef NEURON_SEQ_PERF_CNT_EN
        .busy         (busy),
        .perf_samples (perf_samples),
        .perf_stall   (perf_stall)
`else
        .busy      (busy)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected vector and the cycle of its accepting edge.
    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic prev_valid = 1'b0;

    // Monitor: pops on each out_valid rise, checks data and latency, then
    // re-checks the held data at the handshake.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    cur = sb.pop_front();
                    check("out_data_at_rise", 64'(out_data), 64'(cur.data));
                    check("latency", 64'(cyc - cur.acc), 64'(LATENCY));
                end
            end
            if (out_valid && out_ready) begin
                check("out_data_at_handshake", 64'(out_data), 64'(cur.data));
            end
            prev_valid = out_valid;
        end
    end

    // All tasks are entered at a negedge and return at a negedge.
    task automatic cfg_write(input logic sel, input int addr, input logic [CW-1:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = AW'(addr);
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic send(input logic [IN_BITS-1:0] d, input logic [31:0] exp, input bit push);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        if (push) sb.push_back('{exp, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall);
        int t = 0;
        out_ready = 1'b0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
        if (stall > 0) begin
            check("in_ready_in_hold", 64'(in_ready), 64'd0);
            check("busy_in_hold", 64'(busy), 64'd1);
            repeat (stall) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
        check("busy_after_hs", 64'(busy), 64'd0);
    endtask

    function automatic logic [CW-1:0] conn_word(input int i0, input int i1, input int i2,
                                                input int i3, input int i4, input int i5);
        logic [CW-1:0] w;
        w = '0;
        w[0*6 +: 6] = 6'(i0);
        w[1*6 +: 6] = 6'(i1);
        w[2*6 +: 6] = 6'(i2);
        w[3*6 +: 6] = 6'(i3);
        w[4*6 +: 6] = 6'(i4);
        w[5*6 +: 6] = 6'(i5);
        return w;
    endfunction

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Every neuron reads input bits 0..5; neuron 0 outputs 3 only for
        // pattern 6'b100000, every other neuron n outputs n mod 4.
        for (int n = 0; n < NEURONS; n++) cfg_write(1'b1, n, conn_word(0, 1, 2, 3, 4, 5));
        for (int n = 0; n < NEURONS; n++) begin
            for (int p = 0; p < 64; p++) begin
                if (n == 0) cfg_write(1'b0, (n << 6) | p, CW'((p == 32) ? 3 : 0));
                else        cfg_write(1'b0, (n << 6) | p, CW'(n % 4));
            end
        end

        // Bit 5 only -> neuron 0 sees pattern 32; 10-cycle stall in HOLD.
        send(64'h20, 32'hE4E4_E4E7, 1'b1);
        drain(10);

        // Rejected config write during RUN: TT[1][0] would become 2.
        send(64'h0, 32'hE4E4_E4E4, 1'b1);
        repeat (3) @(negedge clk);
        cfg_write(1'b0, (1 << 6) | 0, CW'(2));
        check("cfg_err_pulse", 64'(cfg_err), 64'd1);
        @(negedge clk);
        check("cfg_err_one_cycle", 64'(cfg_err), 64'd0);
        drain(0);

        // Table must be unchanged: neuron 1 still gives 1 on pattern 0.
        send(64'h0, 32'hE4E4_E4E4, 1'b1);
        drain(0);

        // Reset in cycle 5 of RUN aborts the pass.
        send(64'h20, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three passes with four stall cycles each; tables survived reset.
        for (int i = 0; i < 3; i++) begin
            send(64'h20, 32'hE4E4_E4E7, 1'b1);
            drain(4);
        end
`ifdef NEURON_SEQ_PERF_CNT_EN
        check("perf_samples", 64'(perf_samples), 64'd3);
        check("perf_stall", 64'(perf_stall), 64'd12);
`endif

        // Neuron 15 gathers bits {10,63,40,7,33,20}, TT = p[1:0]^p[3:2]^p[5:4].
        cfg_write(1'b1, 15, conn_word(10, 63, 40, 7, 33, 20));
        for (int p = 0; p < 64; p++) begin
            cfg_write(1'b0, (15 << 6) | p, CW'((p & 3) ^ ((p >> 2) & 3) ^ ((p >> 4) & 3)));
        end

        // Bits 10,40,33 -> pattern 21 -> 1.
        send((64'd1 << 10) | (64'd1 << 40) | (64'd1 << 33), 32'h64E4_E4E4, 1'b1);
        drain(0);
        // Bits 63,7,20 -> pattern 42 -> 2.
        send((64'd1 << 63) | (64'd1 << 7) | (64'd1 << 20), 32'hA4E4_E4E4, 1'b1);
        drain(2);

        // Bits 10,40 -> pattern 5 -> 0; out_ready held high gives a 1-cycle pulse.
        out_ready = 1'b1;
        send((64'd1 << 10) | (64'd1 << 40), 32'h24E4_E4E4, 1'b1);
        begin
            int t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("pulse_seen", 64'(out_valid), 64'd1);
            @(negedge clk);
            check("pulse_one_cycle", 64'(out_valid), 64'd0);
            check("pulse_in_ready", 64'(in_ready), 64'd1);
        end
        out_ready = 1'b0;

        // Config write in the accepting cycle lands before the first read:
        // TT[0][0] = 2 and input 0 -> slice 0 = 2.
        cfg_we   = 1'b1;
        cfg_sel  = 1'b0;
        cfg_addr = AW'(0);
        cfg_data = CW'(2);
        in_data  = '0;
        in_valid = 1'b1;
        sb.push_back('{32'h24E4_E4E6, cyc + 1});
        @(negedge clk);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        drain(0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
